// File: rtl/vga_scan_gen_pkg.sv
// Default 640x480@60 raster timing constants shared by the scan generator,
// its counters and the bus interface.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int FRAME_W = 8;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // Sync polarity value: the active level of hsync/vsync.
  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  typedef logic [CNT_W-1:0]   coord_t;
  typedef logic [FRAME_W-1:0] frame_t;

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster bus: pixel enable in, coordinates / syncs / strobes out.
// master = timing generator, slave = overlay or colour-mux consumer.
interface vga_scan_gen_if;
  import vga_timing_pkg::*;

  logic   pix_en;
  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   display_on;
  logic   line_start;
  logic   frame_start;
  frame_t frame_cnt;

  modport master (
    input  pix_en,
    output x, y, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    output pix_en,
    input  x, y, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_scan_gen_scan_counter.sv
// Modulo-N up counter with enable; exposes its next value so downstream
// decode can be registered in lockstep with the count.
module scan_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    wrap    = en && (cnt == LAST);
    cnt_nxt = cnt;
    if (en) cnt_nxt = wrap ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: x/y scan, syncs, display window and line/frame strobes.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY = H_DISPLAY_DEF,
  parameter int   H_FRONT   = H_FRONT_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BACK    = H_BACK_DEF,
  parameter int   V_DISPLAY = V_DISPLAY_DEF,
  parameter int   V_FRONT   = V_FRONT_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BACK    = V_BACK_DEF,
  parameter logic SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input logic            clk,
  input logic            rst,
  vga_scan_gen_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_DISP_C = coord_t'(H_DISPLAY);
  localparam coord_t V_DISP_C = coord_t'(V_DISPLAY);
  localparam coord_t HS_LO    = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_HI    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO    = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_HI    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  coord_t h_cnt, h_nxt, v_cnt, v_nxt;
  logic   h_wrap, v_wrap, v_en;
  logic   hsync_q, vsync_q, de_q, line_q, frame_q;

  assign v_en = bus.pix_en & h_wrap;

  scan_counter #(.N(H_TOTAL), .W(CNT_W)) u_h (
    .clk(clk), .rst(rst), .en(bus.pix_en),
    .cnt(h_cnt), .cnt_nxt(h_nxt), .wrap(h_wrap)
  );

  scan_counter #(.N(V_TOTAL), .W(CNT_W)) u_v (
    .clk(clk), .rst(rst), .en(v_en),
    .cnt(v_cnt), .cnt_nxt(v_nxt), .wrap(v_wrap)
  );

  // Decode from the next-state counters so the registered flags line up
  // with the registered x/y; with pix_en low next==current, so they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hsync_q <= in_window(h_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync_q <= in_window(v_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      de_q    <= (h_nxt < H_DISP_C) && (v_nxt < V_DISP_C);
      line_q  <= h_wrap;
      frame_q <= v_wrap;
    end
  end

  assign bus.x           = h_cnt;
  assign bus.y           = v_cnt;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.display_on  = de_q;
  assign bus.line_start  = line_q;
  assign bus.frame_start = frame_q;

`ifdef VGA_FRAME_CNT_EN
  frame_t fcnt_q;

  // Steps on the same edge that raises frame_start, so both appear together.
  always_ff @(posedge clk) begin
    if (rst)         fcnt_q <= '0;
    else if (v_wrap) fcnt_q <= fcnt_q + 8'd1;
  end

  assign bus.frame_cnt = fcnt_q;
`else
  assign bus.frame_cnt = '0;
`endif

endmodule
